// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-port arbiter in front of a single-port data memory (combinational
//   read, posedge write). Port C is the core load/store unit, port L is the
//   loader/debug path. One access per cycle, req/gnt handshake, registered
//   read data one cycle after the grant.
//
//   Arbitration:
//     - C has priority, but an L request that has waited MAX_WAIT cycles wins.
//     - L may hold the memory for a burst with l_lock; the burst is cut after
//       LOCK_MAX beats, followed by one cycle where C has strict priority.
//       l_lock must drop before a new burst can start.
//
//   Optional feature macro: DMEM_ARB_RANGE_CHK_EN
//     Defined   : adds DEPTH parameter and c_err/l_err outputs; out-of-range or
//                 misaligned accesses are granted but do not write, and reads
//                 return zero with err pulsing alongside rvalid.
//     Undefined : addresses wrap in the memory, no err ports.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   c_req/c_we/c_addr/c_wdata       C request (held until c_gnt)
//   c_gnt, c_rvalid, c_rdata        C grant, read-data valid, read data
//   l_req/l_we/l_addr/l_wdata       L request (held until l_gnt)
//   l_lock                          L burst ownership request
//   l_gnt, l_rvalid, l_rdata        L grant, read-data valid, read data
//   mem_write/mem_addr/mem_wdata    to data memory
//   mem_rdata                       from data memory (combinational)
//   c_err, l_err                    (range check only) access error pulse
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned LOCK_MAX = 16
`ifdef DMEM_ARB_RANGE_CHK_EN
    ,
    parameter int unsigned DEPTH    = 256
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    input  logic        l_lock,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] l_rdata,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_RANGE_CHK_EN
    ,
    output logic        c_err,
    output logic        l_err
`endif
);

    localparam logic [1:0] ST_OPEN    = 2'd0;
    localparam logic [1:0] ST_LOCK    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
    // Beat count that, on a further grant, completes the burst.
    localparam logic [7:0] LOCK_LAST  = 8'(LOCK_MAX - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic        relock_blk_q, relock_blk_d;
    logic        c_rvalid_q, c_rvalid_d;
    logic        l_rvalid_q, l_rvalid_d;
    logic [31:0] c_rdata_q, c_rdata_d;
    logic [31:0] l_rdata_q, l_rdata_d;

    logic        starve;
    logic        c_win, l_win, any_win;
    logic        win_we;
    logic [31:0] win_addr, win_wdata;
    logic        acc_err;
    logic [31:0] rd_word;

    // ---------------- arbitration ----------------
    always_comb begin
        c_win  = 1'b0;
        l_win  = 1'b0;
        starve = (wait_cnt_q == MAX_WAIT_C);
        case (state_q)
            ST_LOCK: begin
                l_win = l_req;
            end
            ST_RELEASE: begin
                // starvation guard deliberately ignored for this one cycle
                c_win = c_req;
                l_win = l_req & ~c_req;
            end
            default: begin
                l_win = l_req & (~c_req | starve);
                c_win = c_req & ~l_win;
            end
        endcase
        // nothing reaches memory while reset is held
        if (!rst_n) begin
            c_win = 1'b0;
            l_win = 1'b0;
        end
    end

    assign any_win = c_win | l_win;

    always_comb begin
        win_we    = 1'b0;
        win_addr  = 32'h0;
        win_wdata = 32'h0;
        if (c_win) begin
            win_we    = c_we;
            win_addr  = c_addr;
            win_wdata = c_wdata;
        end else if (l_win) begin
            win_we    = l_we;
            win_addr  = l_addr;
            win_wdata = l_wdata;
        end
    end

`ifdef DMEM_ARB_RANGE_CHK_EN
    assign acc_err = any_win &
                     (({2'b00, win_addr[31:2]} >= 32'(DEPTH)) | (win_addr[1:0] != 2'b00));
`else
    assign acc_err = 1'b0;
`endif

    assign c_gnt     = c_win;
    assign l_gnt     = l_win;
    assign mem_write = win_we & ~acc_err;
    assign mem_addr  = win_addr;
    assign mem_wdata = win_wdata;
    assign rd_word   = acc_err ? 32'h0 : mem_rdata;

    // ---------------- FSM / counters ----------------
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        // a dropped l_lock re-arms burst entry
        relock_blk_d = relock_blk_q & l_lock;
        case (state_q)
            ST_LOCK: begin
                if (!l_lock) begin
                    state_d    = ST_OPEN;
                    beat_cnt_d = 8'd0;
                end else if (l_win) begin
                    if (beat_cnt_q == LOCK_LAST) begin
                        state_d      = ST_RELEASE;
                        beat_cnt_d   = 8'd0;
                        relock_blk_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            ST_RELEASE: begin
                state_d = ST_OPEN;
            end
            default: begin
                state_d = ST_OPEN;
                if (l_win && l_lock && !relock_blk_q) begin
                    // the granting beat is the first of the burst
                    if (LOCK_LAST == 8'd0) begin
                        state_d      = ST_RELEASE;
                        relock_blk_d = 1'b1;
                    end else begin
                        state_d    = ST_LOCK;
                        beat_cnt_d = 8'd1;
                    end
                end
            end
        endcase

        if (!l_req || l_win)  wait_cnt_d = 8'd0;
        else if (!starve)     wait_cnt_d = wait_cnt_q + 8'd1;
        else                  wait_cnt_d = wait_cnt_q;
    end

    // ---------------- read return ----------------
    always_comb begin
        c_rvalid_d = c_win & ~c_we;
        l_rvalid_d = l_win & ~l_we;
        c_rdata_d  = c_rvalid_d ? rd_word : c_rdata_q;
        l_rdata_d  = l_rvalid_d ? rd_word : l_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OPEN;
            wait_cnt_q   <= 8'd0;
            beat_cnt_q   <= 8'd0;
            relock_blk_q <= 1'b0;
            c_rvalid_q   <= 1'b0;
            l_rvalid_q   <= 1'b0;
            c_rdata_q    <= 32'h0;
            l_rdata_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            relock_blk_q <= relock_blk_d;
            c_rvalid_q   <= c_rvalid_d;
            l_rvalid_q   <= l_rvalid_d;
            c_rdata_q    <= c_rdata_d;
            l_rdata_q    <= l_rdata_d;
        end
    end

    assign c_rvalid = c_rvalid_q;
    assign l_rvalid = l_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign l_rdata  = l_rdata_q;

`ifdef DMEM_ARB_RANGE_CHK_EN
    logic c_err_q, c_err_d, l_err_q, l_err_d;

    always_comb begin
        c_err_d = c_win & acc_err;
        l_err_d = l_win & acc_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_err_q <= 1'b0;
            l_err_q <= 1'b0;
        end else begin
            c_err_q <= c_err_d;
            l_err_q <= l_err_d;
        end
    end

    assign c_err = c_err_q;
    assign l_err = l_err_q;
`endif

endmodule
